// File: rtl/swo_defs.sv
// Shared definitions for the SWO NRZ (UART 8N1) decoder: FSM encoding and frame timing constants.
package swo_defs;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } swo_state_e;

  // Frames are one start bit, DATA_BITS data bits (LSB first), one stop bit.
  localparam int DATA_BITS   = 8;
  localparam int MIN_DIV     = 4;
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/swo_byte_fifo.sv
// Byte FIFO with registered head-of-queue output; a push into an empty FIFO is visible one cycle later.
module swo_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     ext_clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop_ready,
  output logic [7:0]               head_data,
  output logic                     head_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [7:0]       head_data_reg;
  logic             head_valid_reg;
  logic             pop, push_ok, bypass;

  assign pop     = head_valid_reg & pop_ready;
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  // The incoming byte becomes the new head when nothing older survives this cycle.
  assign bypass = push_ok && (count_reg == (pop ? CNT_W'(1) : CNT_W'(0)));

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop)     rd_ptr_next = rd_ptr_reg + 1'b1;
    if (push_ok && !pop)      count_next = count_reg + 1'b1;
    else if (!push_ok && pop) count_next = count_reg - 1'b1;
  end

  always_ff @(posedge ext_clock) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge ext_clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_data_reg  <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      head_valid_reg <= (count_next != '0);
      if (bypass)                 head_data_reg <= push_data;
      else if (count_next != '0)  head_data_reg <= mem[rd_ptr_next];
    end
  end

  assign head_data  = head_data_reg;
  assign head_valid = head_valid_reg;
  assign count      = count_reg;

endmodule

// File: rtl/swo_nrz_decoder.sv
// SWO NRZ (8N1) receiver: synchronizer, bit-timing FSM, byte FIFO, sticky overflow and framing-error pulse.
// Optional byte matcher on trig_match is built only when SWO_MATCH_EN is defined.
module swo_nrz_decoder
  import swo_defs::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        ext_clock,
  input  logic                        reset,
  input  logic                        swo,
  input  logic [DIV_W-1:0]            baud_div,
  output logic [7:0]                  m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_err,
  output logic                        overflow,
  input  logic                        ovf_clr,
  input  logic [7:0]                  match_value,
  output logic                        trig_match
);
  localparam int BIT_W = $clog2(DATA_BITS);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   swo_prev_reg;
  logic                   rx, start_edge, expire;

  swo_state_e             state_reg, state_next;
  logic [DIV_W-1:0]       cnt_reg, cnt_next;
  logic [DIV_W-1:0]       div_reg, div_next, div_eff;
  logic [BIT_W-1:0]       bit_reg, bit_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   stop_ok, stop_bad, match_next;

  logic                   push_reg, frame_err_reg, overflow_reg, trig_match_reg;
  logic                   fifo_full, fifo_empty, fifo_drop;
  logic                   unused_fifo_flags;

  assign rx         = sync_reg[SYNC_STAGES-1];
  assign start_edge = swo_prev_reg & ~rx;
  assign div_eff    = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
  assign expire     = (cnt_reg <= DIV_W'(1));

  // Flops preset high so reset looks like an idle line and never fakes a start edge.
  always_ff @(posedge ext_clock or negedge reset) begin
    if (!reset) begin
      sync_reg     <= '1;
      swo_prev_reg <= 1'b1;
    end else begin
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], swo};
      swo_prev_reg <= rx;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_edge) begin
          div_next   = div_eff;
          cnt_next   = div_eff >> 1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (!expire) cnt_next = cnt_reg - 1'b1;
        else if (!rx) begin
          bit_next   = '0;
          cnt_next   = div_reg;
          state_next = ST_DATA;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!expire) cnt_next = cnt_reg - 1'b1;
        else begin
          shift_next = {rx, shift_reg[DATA_BITS-1:1]};
          cnt_next   = div_reg;
          if (bit_reg == BIT_W'(DATA_BITS - 1)) state_next = ST_STOP;
          else                                  bit_next   = bit_reg + 1'b1;
        end
      end
      ST_STOP: begin
        if (!expire) cnt_next = cnt_reg - 1'b1;
        else if (rx) begin
          stop_ok    = 1'b1;
          state_next = ST_IDLE;
        end else begin
          stop_bad   = 1'b1;
          state_next = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (rx) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef SWO_MATCH_EN
  assign match_next = stop_ok && (shift_reg == match_value);
`else
  logic unused_match_value;
  assign unused_match_value = ^match_value;
  assign match_next         = 1'b0;
`endif

  always_ff @(posedge ext_clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      div_reg        <= DIV_W'(MIN_DIV);
      bit_reg        <= '0;
      shift_reg      <= '0;
      push_reg       <= 1'b0;
      frame_err_reg  <= 1'b0;
      trig_match_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      div_reg        <= div_next;
      bit_reg        <= bit_next;
      shift_reg      <= shift_next;
      push_reg       <= stop_ok;
      frame_err_reg  <= stop_bad;
      trig_match_reg <= match_next;
      // A drop in the same cycle as a clear leaves the flag set.
      if (fifo_drop)    overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
    end
  end

  swo_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ext_clock  (ext_clock),
    .reset      (reset),
    .push       (push_reg),
    .push_data  (shift_reg),
    .pop_ready  (m_ready),
    .head_data  (m_data),
    .head_valid (m_valid),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .drop       (fifo_drop)
  );

  assign unused_fifo_flags = fifo_full ^ fifo_empty;
  assign frame_err         = frame_err_reg;
  assign overflow          = overflow_reg;
  assign trig_match        = trig_match_reg;

endmodule

// File: tb/tb_swo_nrz_decoder.sv
// Randomized bench for swo_nrz_decoder; expected bytes, drops, framing errors and matches come from a byte-level model.
module tb_swo_nrz_decoder;
  localparam int DEPTH = 16;
  localparam int DIV_W = 16;
`ifdef SWO_MATCH_EN
  localparam bit MATCH_ON = 1'b1;
`else
  localparam bit MATCH_ON = 1'b0;
`endif

  logic                   ext_clock = 1'b0;
  logic                   reset = 1'b0;
  logic                   swo = 1'b1;
  logic [DIV_W-1:0]       baud_div = 16'd8;
  logic [7:0]             m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   frame_err;
  logic                   overflow;
  logic                   ovf_clr = 1'b0;
  logic [7:0]             match_value = 8'h00;
  logic                   trig_match;

  int         n_compared = 0;
  int         n_mismatched = 0;
  int         ready_mode = 1;
  int         fe_cycles = 0;
  int         trig_cycles = 0;
  int         model_fe = 0;
  int         model_matches = 0;
  bit         model_ovf = 1'b0;
  logic [7:0] exp_q [$];

  swo_nrz_decoder #(
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .ext_clock   (ext_clock),
    .reset       (reset),
    .swo         (swo),
    .baud_div    (baud_div),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .fifo_count  (fifo_count),
    .frame_err   (frame_err),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .match_value (match_value),
    .trig_match  (trig_match)
  );

  always #5 ext_clock = ~ext_clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ext_clock);
      #1;
    end
  endtask

  // Consumer side: every accepted byte must be the oldest one the model still expects.
  task automatic monitor_loop();
    logic [7:0] exp_b;
    forever begin
      @(negedge ext_clock);
      if (reset) begin
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check_value("rx_extra_byte", {24'h0, m_data}, 32'h100);
          end else begin
            exp_b = exp_q.pop_front();
            $display("rx byte 0x%02h (model 0x%02h)", m_data, exp_b);
            check_value("rx_byte", {24'h0, m_data}, {24'h0, exp_b});
          end
        end
        if (frame_err)  fe_cycles++;
        if (trig_match) trig_cycles++;
      end
    end
  endtask

  task automatic ready_loop();
    m_ready = 1'b0;
    forever begin
      @(posedge ext_clock);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  // Serialize one 8N1 frame at div cycles per bit; a low stop bit is followed by a 40-cycle break.
  task automatic send_frame(input logic [7:0] b, input bit stop_hi, input int div, input bit chg_div);
    swo = 1'b0;
    tick(div);
    if (chg_div) baud_div = 16'($urandom_range(0, 20));
    for (int i = 0; i < 8; i++) begin
      swo = b[i];
      tick(div);
    end
    if (stop_hi) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else                      model_ovf = 1'b1;
      if (b == match_value) model_matches++;
    end else begin
      model_fe++;
    end
    swo = stop_hi;
    tick(div);
    if (!stop_hi) tick(40);
    swo = 1'b1;
    tick(div);
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < limit) begin
      tick(1);
      n++;
    end
    tick(2);
    check_value(tag, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string pfx);
    check_value({pfx, "_m_valid"},    m_valid, 0);
    check_value({pfx, "_m_data"},     m_data, 0);
    check_value({pfx, "_fifo_count"}, fifo_count, 0);
    check_value({pfx, "_frame_err"},  frame_err, 0);
    check_value({pfx, "_overflow"},   overflow, 0);
    check_value({pfx, "_trig_match"}, trig_match, 0);
  endtask

  initial begin
    int n, t0, f0, div;
    bit ok;
    logic [7:0] b;
    fork
      monitor_loop();
      ready_loop();
    join_none

    tick(3);
    check_all_zero("reset");
    reset = 1'b1;
    tick(4);

    // Single byte held at the head while the consumer stalls.
    ready_mode = 0;
    baud_div = 16'd8;
    send_frame(8'hA5, 1'b1, 8, 1'b0);
    n = 0;
    while (!m_valid && n < 200) begin tick(1); n++; end
    check_value("t1_valid", m_valid, 1);
    check_value("t1_data", m_data, 8'hA5);
    check_value("t1_count", fifo_count, 1);
    check_value("t1_frame_err", fe_cycles, 0);
    ready_mode = 1;
    wait_drain("t1_drain", 100);

    // Short low glitch must be rejected at the start-bit midpoint.
    swo = 1'b0;
    tick(2);
    swo = 1'b1;
    tick(40);
    check_value("t2_count", fifo_count, 0);
    check_value("t2_valid", m_valid, 0);
    check_value("t2_frame_err", fe_cycles, 0);

    // Framing error with a break, then a good byte.
    f0 = fe_cycles;
    send_frame(8'h3C, 1'b0, 8, 1'b0);
    tick(5);
    send_frame(8'h55, 1'b1, 8, 1'b0);
    wait_drain("t3_drain", 200);
    check_value("t3_fe_pulses", fe_cycles - f0, 1);

    // Overflow: 17 bytes into a stalled 16-deep FIFO; baud_div below the minimum runs at 4.
    ready_mode = 0;
    baud_div = 16'd1;
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b1, 4, 1'b0);
    tick(20);
    check_value("t4_count", fifo_count, DEPTH);
    check_value("t4_overflow", overflow, model_ovf);
    check_value("t4_head", m_data, 8'h00);
    ready_mode = 1;
    wait_drain("t4_drain", 400);
    check_value("t4_count_empty", fifo_count, 0);
    check_value("t4_overflow_sticky", overflow, model_ovf);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    model_ovf = 1'b0;
    tick(1);
    check_value("t4_overflow_clr", overflow, model_ovf);

    // Byte matcher.
    match_value = 8'h7E;
    baud_div = 16'd8;
    t0 = trig_cycles;
    f0 = model_matches;
    send_frame(8'h11, 1'b1, 8, 1'b0);
    send_frame(8'h7E, 1'b1, 8, 1'b0);
    wait_drain("t5_drain", 200);
    check_value("t5_trig", trig_cycles - t0, MATCH_ON ? (model_matches - f0) : 0);

    // Reset mid-frame with a byte parked in the FIFO.
    ready_mode = 0;
    send_frame(8'h44, 1'b1, 8, 1'b0);
    tick(20);
    check_value("t6_count_pre", fifo_count, 1);
    b = 8'h9A;
    swo = 1'b0;
    tick(8);
    for (int i = 0; i < 3; i++) begin
      swo = b[i];
      tick(8);
    end
    reset = 1'b0;
    #1;
    check_all_zero("t6_in_reset");
    exp_q.delete();
    swo = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(5);
    ready_mode = 1;
    send_frame(8'hC3, 1'b1, 8, 1'b0);
    wait_drain("t6_drain", 200);

    // Random frames, random rates (some changed mid-frame), random consumer stalls.
    ready_mode = 2;
    match_value = 8'($urandom_range(0, 255));
    for (int k = 0; k < 24; k++) begin
      div = $urandom_range(4, 12);
      b   = (k % 5 == 0) ? match_value : 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 7) != 0);
      baud_div = 16'(div);
      send_frame(b, ok, div, 1'($urandom_range(0, 1)));
      tick($urandom_range(0, div));
    end
    wait_drain("rand_drain", 2000);
    check_value("final_frame_err", fe_cycles, model_fe);
    check_value("final_trig", trig_cycles, MATCH_ON ? model_matches : 0);
    check_value("final_overflow", overflow, model_ovf);
    check_value("final_count", fifo_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
